// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: op_sel encodings, FSM state encoding and operand width.
// The ALU's opcode-to-op_sel mapping uses the same encodings.
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] RV32M_MUL    = 5'b10000;
  localparam logic [4:0] RV32M_MULH   = 5'b10001;
  localparam logic [4:0] RV32M_MULHSU = 5'b10010;
  localparam logic [4:0] RV32M_MULHU  = 5'b10011;
  localparam logic [4:0] RV32M_DIV    = 5'b10100;
  localparam logic [4:0] RV32M_DIVU   = 5'b10101;
  localparam logic [4:0] RV32M_REM    = 5'b10110;
  localparam logic [4:0] RV32M_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rv32m_div_step.sv
// One restoring-division step on the {rem,quot} pair: shift left by one, then
// subtract the divisor and set the new quotient bit when the partial remainder allows it.
module rv32m_div_step
  import rv32m_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [2*W-1:0] pair,
  input  logic [W-1:0]   divisor,
  output logic [2*W-1:0] pair_nxt
);

  logic [W:0]   trial;
  logic         ge;
  logic [W-1:0] rem_nxt;

  // trial needs W+1 bits: the shifted remainder can reach 2*divisor-1
  always_comb begin
    trial    = {pair[2*W-1:W], pair[W-1]};
    ge       = (trial >= {1'b0, divisor});
    rem_nxt  = ge ? (trial[W-1:0] - divisor) : trial[W-1:0];
    pair_nxt = {rem_nxt, pair[W-2:0], ge};
  end

endmodule

// File: rtl/rv32m_iter_muldiv.sv
// Iterative RV32M unit: one shared 64-bit accumulator does shift-add multiply or
// restoring divide one bit per cycle, then a single fix-up cycle applies result signs.
module rv32m_iter_muldiv
  import rv32m_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            op_valid,
  input  logic [4:0]      op_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  // Handshake: op_valid is a level held by the ALU; a request is taken only in IDLE
  // without flush. busy covers CALC/FIX, done pulses one cycle with result valid, never with busy.
  state_t state, state_nxt;

  logic [4:0]        op_q;
  logic [4:0]        count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd, fast_val, result_q;
  logic              sa_q, sb_q, bz_q, fast_q;

  logic              accept;
  logic              sgn_a, sgn_b, sa, sb, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, fast_val_in;
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, p_fix;
  logic [XLEN-1:0]   q_mag, r_mag, fin;

  rv32m_div_step #(.W(XLEN)) u_div_step (
    .pair     (acc),
    .divisor  (opnd),
    .pair_nxt (div_nxt)
  );

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (op_sel)
      RV32M_MULH, RV32M_DIV, RV32M_REM: begin sgn_a = 1'b1; sgn_b = 1'b1; end
      RV32M_MULHSU:                     sgn_a = 1'b1;
      RV32M_MUL, RV32M_MULHU,
      RV32M_DIVU, RV32M_REMU:           ;
      default:                          ;
    endcase
    accept   = (state == ST_IDLE) && op_valid && op_sel[4] && !flush;
    sa       = sgn_a & rs1[XLEN-1];
    sb       = sgn_b & rs2[XLEN-1];
    a_mag    = sa ? -rs1 : rs1;
    b_mag    = sb ? -rs2 : rs2;
    is_div   = op_sel[2];
    div_zero = (rs2 == '0);
    div_ovf  = sgn_a && is_div && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    // op_sel[1] separates REM/REMU from DIV/DIVU
    if (div_zero) fast_val_in = op_sel[1] ? rs1 : '1;
    else          fast_val_in = op_sel[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt = {add_sum, acc[XLEN-1:1]};
    p_fix   = (sa_q ^ sb_q) ? -acc : acc;
    q_mag   = acc[XLEN-1:0];
    r_mag   = acc[2*XLEN-1:XLEN];
    case (op_q)
      RV32M_MUL:                             fin = p_fix[XLEN-1:0];
      RV32M_MULH, RV32M_MULHSU, RV32M_MULHU: fin = p_fix[2*XLEN-1:XLEN];
      // a zero divisor must leave the all-ones quotient unnegated
      RV32M_DIV, RV32M_DIVU:                 fin = ((sa_q ^ sb_q) && !bz_q) ? -q_mag : q_mag;
      RV32M_REM, RV32M_REMU:                 fin = sa_q ? -r_mag : r_mag;
      default:                               fin = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) state_nxt = ST_CALC;
        ST_CALC: begin
          if (fast_q)              state_nxt = ST_DONE;
          else if (count == 5'd31) state_nxt = ST_FIX;
        end
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      fast_val <= '0;
      result_q <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      fast_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= op_sel;
        sa_q     <= sa;
        sb_q     <= sb;
        bz_q     <= div_zero;
        fast_q   <= FAST_SPEC && is_div && (div_zero || div_ovf);
        fast_val <= fast_val_in;
        count    <= '0;
        acc      <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        opnd     <= is_div ? b_mag : a_mag;
      end else if (state == ST_CALC && !flush) begin
        count <= count + 5'd1;
        acc   <= op_q[2] ? div_nxt : mul_nxt;
        if (fast_q) result_q <= fast_val;
      end else if (state == ST_FIX && !flush) begin
        result_q <= fin;
      end
    end
  end

  assign busy      = (state == ST_CALC) || (state == ST_FIX);
  assign done      = (state == ST_DONE);
  assign result    = result_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_rv32m_iter_muldiv.sv
// Directed bench for rv32m_iter_muldiv: vector table for every op and the fast
// special cases, plus hand sequences for flush, reset, back-to-back and non-M requests.
module tb_rv32m_iter_muldiv;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [4:0]  op_sel;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];

  rv32m_iter_muldiv #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .op_valid  (op_valid),
    .op_sel    (op_sel),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy && done) overlap_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int busy_cnt = 0;
    int k = 0;
    logic [31:0] got = '0;
    @(negedge clk);
    op_valid = 1'b1; op_sel = op; rs1 = a; rs2 = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    op_valid = 1'b0; rs1 = $urandom; rs2 = $urandom;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin k = c; got = result; break; end
    end
    if (k == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: no done within 100 cycles, expected 0x%08h", name, exp);
      void'(exp_q.pop_front());
    end else begin
      check({name, "_result"}, got, exp_q.pop_front());
      check({name, "_done_cycle"}, k, lat);
      check({name, "_busy_cycles"}, busy_cnt, lat - 1);
      last_result = exp;
    end
  endtask

  initial begin
    int d1, b2, d2, hits;
    logic [31:0] r1, r2;

    vecs[0]  = '{RV32M_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{RV32M_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{RV32M_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{RV32M_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{RV32M_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[5]  = '{RV32M_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[6]  = '{RV32M_DIVU,   32'd100,       32'd7,         32'd14,        34};
    vecs[7]  = '{RV32M_REMU,   32'd100,       32'd7,         32'd2,         34};
    vecs[8]  = '{RV32M_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{RV32M_REMU,   32'd5,         32'd0,         32'd5,         2};
    vecs[10] = '{RV32M_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{RV32M_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vecs[12] = '{RV32M_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vecs[13] = '{RV32M_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 2};
    vecs[14] = '{RV32M_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 34};
    vecs[15] = '{RV32M_MULH,   32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 34};
    vecs[16] = '{RV32M_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 34};
    vecs[17] = '{RV32M_DIV,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 34};
    vecs[18] = '{RV32M_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34};

    // clock/reset
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_sel = '0; rs1 = '0; rs2 = '0;
    last_result = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state",  {30'b0, dbg_state}, 32'd0);

    for (int i = 0; i < NVEC; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // flush during cycle 10 of a DIV
    @(negedge clk);
    op_valid = 1'b1; op_sel = RV32M_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    hits = 0;
    repeat (40) begin @(negedge clk); if (done) hits++; end
    check("flush_no_done", hits, 32'd0);
    check("flush_result_kept", result, last_result);

    // reset during cycle 10 of a MUL
    @(negedge clk);
    op_valid = 1'b1; op_sel = RV32M_MUL; rs1 = 32'd6; rs2 = 32'd7;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy",   {31'b0, busy}, 32'd0);
    check("rst_mid_done",   {31'b0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_state",  {30'b0, dbg_state}, 32'd0);
    last_result = '0;

    // flush together with op_valid in IDLE: no accept
    @(negedge clk);
    op_valid = 1'b1; op_sel = RV32M_MUL; rs1 = 32'd2; rs2 = 32'd2; flush = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", {31'b0, busy}, 32'd0);

    // op_valid held across two back-to-back MULs
    @(negedge clk);
    op_valid = 1'b1; op_sel = RV32M_MUL; rs1 = 32'd3; rs2 = 32'd5;
    @(posedge clk);
    d1 = 0; b2 = 0; d2 = 0; r1 = '0; r2 = '0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (done && d1 == 0) begin
        d1 = c; r1 = result;
      end else if (busy && d1 != 0 && b2 == 0) begin
        b2 = c; op_valid = 1'b0; rs1 = 32'd9;
      end else if (done && b2 != 0) begin
        d2 = c; r2 = result; break;
      end
    end
    check("b2b_first_done",    d1, 32'd34);
    check("b2b_first_result",  r1, 32'd15);
    check("b2b_second_busy",   b2, 32'd36);
    check("b2b_second_done",   d2, 32'd69);
    check("b2b_second_result", r2, 32'd15);

    // non-M op_sel never raises busy
    @(negedge clk);
    op_valid = 1'b1; op_sel = 5'b00101; rs1 = 32'd1; rs2 = 32'd1;
    hits = 0;
    repeat (6) begin @(negedge clk); if (busy || done) hits++; end
    op_valid = 1'b0;
    check("non_m_op_ignored", hits, 32'd0);

    check("busy_done_overlap", overlap_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
